// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: operand/result valid-ready bundle; acc_clr exists only with WALLACE_MULT_ACC_EN
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 32
);
  logic in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] product;
`ifdef WALLACE_MULT_ACC_EN
  logic acc_clr;
  modport master (output in_valid, a, b, signed_mode, acc_clr, out_ready, input in_ready, out_valid, product);
  modport slave (input in_valid, a, b, signed_mode, acc_clr, out_ready, output in_ready, out_valid, product);
`else
  modport master (output in_valid, a, b, signed_mode, out_ready, input in_ready, out_valid, product);
  modport slave (input in_valid, a, b, signed_mode, out_ready, output in_ready, out_valid, product);
`endif
endinterface

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Baugh-Wooley/Wallace multiplier with stall; WALLACE_MULT_ACC_EN adds multiply-accumulate
module wallace_mult_pipe #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst,
  wallace_mult_pipe_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
`ifdef WALLACE_MULT_ACC_EN
  localparam int SW = 3;
`else
  localparam int SW = 2;
`endif
  localparam logic [W2-1:0] ONE = {{(W2-1){1'b0}}, 1'b1};
  localparam logic [W2-1:0] BW_K = (ONE << (W2 - 1)) | (ONE << WIDTH);
  function automatic int rows_at(input int l);
    int n = WIDTH;
    for (int i = 0; i < l; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction
  function automatic int count_levels();
    int n = WIDTH;
    int l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction
  localparam int LEVELS = count_levels();
  localparam int MID = STAGES - 1;
  function automatic logic reg_after(input int p);
    logic r = 1'b0;
    for (int i = 0; i < MID; i++) r = r | ((i + 1) * LEVELS / MID == p);
    return r;
  endfunction
  function automatic logic [2*W2-1:0] csa3(input logic [W2-1:0] x, y, z);
    return {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
  endfunction
  function automatic logic [W2-1:0] ks_add(input logic [W2-1:0] x, y);
    logic [W2-1:0] g = x & y;
    logic [W2-1:0] p = x ^ y;
    for (int d = 1; d < W2; d = d * 2) begin
      g = g | (p & (g << d));
      p = p & (p << d);
    end
    return (x ^ y) ^ (g << 1);
  endfunction
  logic stall, hs, out_valid_d, out_valid_q;
  logic [W2-1:0] product_d, product_q, sum_x, sum_y;
  assign stall = out_valid_q && !bus.out_ready;
  assign hs = out_valid_q && bus.out_ready;
  assign bus.in_ready = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.product = product_q;
  // side = {acc_clr, signed_mode, valid}; it rides alongside the rows through every rank
  for (genvar l = 0; l <= LEVELS; l++) begin : lv
    localparam int N = rows_at(l);
    logic [W2-1:0] rows_d [N];
    logic [W2-1:0] rows [N];
    logic [SW-1:0] side_d, side;
    if (l == 0) begin : g
      always_comb begin
        rows_d = '{default: '0};
        for (int i = 0; i < WIDTH; i++)
          for (int j = 0; j < WIDTH; j++)
            rows_d[i][i+j] = (bus.a[j] & bus.b[i]) ^ (bus.signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
      assign side_d[1:0] = {bus.signed_mode, bus.in_valid};
`ifdef WALLACE_MULT_ACC_EN
      assign side_d[2] = bus.acc_clr;
`endif
    end else begin : g
      localparam int P = rows_at(l - 1);
      always_comb begin
        rows_d = '{default: '0};
        for (int k = 0; k < P / 3; k++)
          {rows_d[2*k], rows_d[2*k+1]} = csa3(lv[l-1].rows[3*k], lv[l-1].rows[3*k+1], lv[l-1].rows[3*k+2]);
        for (int k = 0; k < P % 3; k++) rows_d[2*(P/3)+k] = lv[l-1].rows[3*(P/3)+k];
      end
      assign side_d = lv[l-1].side;
    end
    if (reg_after(l)) begin : r
      logic [W2-1:0] rows_q [N];
      logic [SW-1:0] side_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) side_q <= '0;
        else if (!stall) side_q <= side_d;
      always_ff @(posedge clk)
        if (!stall) rows_q <= rows_d;
      assign rows = rows_q;
      assign side = side_q;
    end else begin : c
      assign rows = rows_d;
      assign side = side_d;
    end
  end
`ifdef WALLACE_MULT_ACC_EN
  logic [W2-1:0] acc_d, acc_q;
  // forwarding the result being handshaked keeps back-to-back accumulations exact
  assign acc_d = hs ? product_q : acc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
`endif
  // signed correction constants join here so signed_mode is consumed at the output rank
  always_comb begin
    {sum_x, sum_y} = csa3(lv[LEVELS].rows[0], lv[LEVELS].rows[1], lv[LEVELS].side[1] ? BW_K : '0);
`ifdef WALLACE_MULT_ACC_EN
    {sum_x, sum_y} = csa3(sum_x, sum_y, lv[LEVELS].side[2] ? '0 : acc_d);
`endif
    out_valid_d = stall ? out_valid_q : lv[LEVELS].side[0];
    product_d = stall ? product_q : (lv[LEVELS].side[0] ? ks_add(sum_x, sum_y) : '0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      product_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      product_q <= product_d;
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed vector table plus latency, stall, reset and accumulate sequences
module tb_wallace_mult_pipe;
  localparam int W = 32;
  localparam int ST = 4;
  typedef struct {
    logic [W-1:0] a, b;
    logic sm;
    logic [2*W-1:0] p;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wallace_mult_pipe_if #(.WIDTH(W)) bus ();
  wallace_mult_pipe #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
  vec_t tbl [12];
  logic [2*W-1:0] exp_q [$];
  int acc_cyc [$];
  int out_cyc [$];
  int cyc = 0;
  int passed = 0;
  int total = 0;
`ifdef WALLACE_MULT_ACC_EN
  logic clr = 1'b1;
  assign bus.acc_clr = clr;
`endif
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    logic [2*W-1:0] xe = sm ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    logic [2*W-1:0] ye = sm ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction
  // output scoreboard; the handshake is evaluated mid-cycle, before the edge that completes it
  always @(negedge clk) if (!rst) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got %h want no result", bus.product);
      end else begin
        check("out", bus.product, exp_q.pop_front());
        out_cyc.push_back(cyc);
      end
    end
    if (!bus.out_valid) check("idle_product_zero", bus.product, '0);
  end
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic sm, input logic [2*W-1:0] e);
    logic done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = ta;
    bus.b = tb;
    bus.signed_mode = sm;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      $display("FAIL send_timeout: in_ready=0 for 40 cycles, want 1");
    end
  endtask
  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d results missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic stream_check(input string name, input int n, input int extra);
    check({name, "_count"}, 64'(out_cyc.size()), 64'(n));
    if (out_cyc.size() == n && acc_cyc.size() == n) begin
      check({name, "_latency"}, 64'(out_cyc[0] - acc_cyc[0]), 64'(ST + extra));
      check({name, "_back_to_back"}, 64'(out_cyc[n-1] - out_cyc[0]), 64'(n - 1));
    end
    acc_cyc.delete();
    out_cyc.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    tbl[1]  = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA};
    tbl[2]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    tbl[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    tbl[4]  = '{32'h00000000, 32'h12345678, 1'b0, 64'h0000000000000000};
    tbl[5]  = '{32'hDEADBEEF, 32'h00000000, 1'b1, 64'h0000000000000000};
    tbl[6]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000};
    tbl[7]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
    tbl[8]  = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001FFFFFFFE};
    tbl[9]  = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE};
    tbl[10] = '{32'h00000005, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFFFFFFFFDD};
    tbl[11] = '{32'hFFFFFFFF, 32'h80000000, 1'b0, 64'h7FFFFFFF80000000};
    bus.in_valid = 1'b1;
    bus.a = 32'h1234;
    bus.b = 32'h5678;
    bus.signed_mode = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    #2;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_product", bus.product, '0);
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = 1'(i % 2);
      @(posedge clk);
      #1;
      check("idle_out_valid", 64'(bus.out_valid), 64'(0));
    end
    bus.out_ready = 1'b1;
    acc_cyc.delete();
    out_cyc.delete();
    send(tbl[0].a, tbl[0].b, tbl[0].sm, tbl[0].p);
    drain();
    stream_check("single", 1, 0);
    for (int i = 0; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].p);
    drain();
    stream_check("table", 12, 0);
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra = $urandom;
      logic [W-1:0] rb = $urandom;
      logic rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, ref_mul(ra, rb, rs));
    end
    drain();
    stream_check("random", 8, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(tbl[i+1].a, tbl[i+1].b, tbl[i+1].sm, tbl[i+1].p);
    bus.in_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      check("stall_out_valid", 64'(bus.out_valid), 64'(1));
      check("stall_product", bus.product, tbl[1].p);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    drain();
    stream_check("stall", 4, 3);
    for (int i = 0; i < 3; i++) send(tbl[i+7].a, tbl[i+7].b, tbl[i+7].sm, tbl[i+7].p);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    bus.in_valid = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_product", bus.product, '0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_stale", 64'(bus.out_valid), 64'(0));
    acc_cyc.delete();
    out_cyc.delete();
    send(32'd5, 32'd7, 1'b0, 64'd35);
    drain();
    stream_check("post_rst", 1, 0);
`ifdef WALLACE_MULT_ACC_EN
    clr = 1'b1;
    send(32'd2, 32'd3, 1'b0, 64'd6);
    clr = 1'b0;
    send(32'd4, 32'd5, 1'b0, 64'd26);
    send(32'd1, 32'd1, 1'b0, 64'd27);
    clr = 1'b1;
    send(32'd2, 32'd2, 1'b0, 64'd4);
    drain();
    stream_check("acc", 4, 0);
`endif
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
